// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-bus access and stall controller (posted uncached stores, blocking loads).
// Optional watchdog is compiled in when DM_ACCESS_TIMEOUT_EN is defined.
module dm_access_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             uncached,
    input  logic             cache_stall,
    input  logic             flush,
    output logic             data_req,
    output logic             data_wr,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    output logic             dm_stall,
    output logic             load_done,
    output logic [CNT_W-1:0] outstanding,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, LOAD_WAIT} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic             flushed, flushed_nxt;
    logic             wr_q, wr_nxt;
    logic             any_op, acc, bus_inc, bus_dec, wd_hit;

    assign any_op      = mem_read | mem_write;
    assign acc         = any_op & uncached & ~flush;
    assign data_req    = (state == REQ);
    assign data_wr     = wr_q;
    assign bus_inc     = data_req & data_addr_ok;
    assign bus_dec     = data_data_ok & (out_cnt != '0);
    assign outstanding = out_cnt;
    assign load_done   = (state == LOAD_WAIT) & data_data_ok & ~flushed;

`ifdef DM_ACCESS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;

    // Any bus handshake proves the slave is alive and restarts the count.
    assign wd_active   = ((state != IDLE) | (out_cnt != '0)) & ~data_data_ok & ~data_addr_ok;
    assign wd_hit      = wd_active & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wd_cnt <= '0;
        else if (!wd_active || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_hit      = 1'b0;
    // Watchdog compiled out; TIMEOUT_CYCLES stays only so both builds share one interface.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nxt   = state;
        wr_nxt      = wr_q;
        flushed_nxt = flushed;
        case (state)
            IDLE: begin
                if (acc && mem_write) begin
                    if (out_cnt < MAX_CNT) begin
                        state_nxt = REQ;
                        wr_nxt    = 1'b1;
                    end
                end else if (acc && mem_read) begin
                    wr_nxt    = 1'b0;
                    state_nxt = (out_cnt == '0) ? REQ : DRAIN;
                end
            end
            DRAIN: begin
                // A killed load must never reach the bus, so flush wins over the drain exit.
                if (flush)
                    state_nxt = IDLE;
                else if ((out_cnt == '0) || ((out_cnt == ONE) && data_data_ok))
                    state_nxt = REQ;
            end
            REQ: begin
                if (data_addr_ok)
                    state_nxt = wr_q ? IDLE : LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (data_data_ok && (out_cnt == ONE))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (flush && ((state == REQ) || (state == LOAD_WAIT)))
            flushed_nxt = 1'b1;
        if (wd_hit)
            state_nxt = IDLE;
        if (state_nxt == IDLE)
            flushed_nxt = 1'b0;
    end

    always_comb begin
        out_cnt_nxt = out_cnt;
        if (bus_inc && !bus_dec)
            out_cnt_nxt = out_cnt + ONE;
        else if (!bus_inc && bus_dec)
            out_cnt_nxt = out_cnt - ONE;
        if (wd_hit)
            out_cnt_nxt = '0;
    end

    // The stall drops only in the completing cycle so the instruction advances exactly once.
    always_comb begin
        dm_stall = 1'b0;
        if (!flush && any_op) begin
            if (flushed) begin
                dm_stall = 1'b1;
            end else if (uncached) begin
                case (state)
                    REQ:       dm_stall = ~(data_addr_ok & wr_q);
                    LOAD_WAIT: dm_stall = ~data_data_ok;
                    default:   dm_stall = 1'b1;
                endcase
            end else begin
                dm_stall = cache_stall | (out_cnt != '0);
            end
        end
        if (wd_hit)
            dm_stall = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            out_cnt <= '0;
            flushed <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_cnt <= out_cnt_nxt;
            flushed <= flushed_nxt;
            wr_q    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: transaction-level model checked every cycle plus pinned literals.
// Exercises the watchdog as well when DM_ACCESS_TIMEOUT_EN is defined.
module tb_dm_access_ctrl;

    localparam int MAX_OUT = 4;
    localparam int TMO     = 16;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             mem_read = 1'b0, mem_write = 1'b0, uncached = 1'b0;
    logic             cache_stall = 1'b0, flush = 1'b0;
    logic             data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic             data_req, data_wr, dm_stall, load_done, timeout_err;
    logic [CNT_W-1:0] outstanding;

    int n_vec  = 0;
    int n_fail = 0;

    // Transaction-level model: one in-flight pipeline access plus a count of bus requests.
    int m_cnt = 0;
    int m_wd  = 0;
    bit m_busy = 0, m_load = 0, m_armed = 0, m_issued = 0, m_killed = 0;

    dm_access_ctrl #(.MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .mem_read(mem_read), .mem_write(mem_write),
        .uncached(uncached), .cache_stall(cache_stall), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .dm_stall(dm_stall), .load_done(load_done),
        .outstanding(outstanding), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input bit unc, input bit cs,
                                 input bit fl, input bit aok, input bit dok);
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; uncached = unc; cache_stall = cs;
        flush = fl; data_addr_ok = aok; data_data_ok = dok;
        #1;
    endtask

    task automatic idleCycle(input bit dok);
        applyStimulus(0, 0, 0, 0, 0, 0, dok);
    endtask

    task automatic fastStore();
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
    endtask

    always @(negedge clk) begin : model_check
        bit acc, e_req, e_done, e_stall, hit, issue, dec, active;
        int cnt_n;
        if (!resetn) begin
            m_cnt = 0; m_wd = 0;
            m_busy = 0; m_load = 0; m_armed = 0; m_issued = 0; m_killed = 0;
        end
        acc    = (mem_read | mem_write) & uncached & ~flush;
        e_req  = m_busy & m_armed & ~m_issued;
        e_done = m_busy & m_load & m_issued & data_data_ok & ~m_killed;
        active = m_busy || (m_cnt != 0);
`ifdef DM_ACCESS_TIMEOUT_EN
        hit = resetn && active && !data_data_ok && !data_addr_ok && (m_wd == TMO - 1);
`else
        hit = 1'b0;
`endif
        if (flush || !(mem_read || mem_write)) e_stall = 0;
        else if (m_killed)                     e_stall = 1;
        else if (uncached) begin
            if (!m_busy)      e_stall = 1;
            else if (!m_load) e_stall = !(e_req && data_addr_ok);
            else              e_stall = !(m_issued && data_data_ok);
        end else              e_stall = cache_stall || (m_cnt != 0);
        if (hit) e_stall = 0;

        checkOutput("data_req", data_req, e_req);
        if (e_req) checkOutput("data_wr", data_wr, !m_load);
        checkOutput("dm_stall", dm_stall, e_stall);
        checkOutput("load_done", load_done, e_done);
        checkOutput("outstanding", outstanding, m_cnt);
        checkOutput("timeout_err", timeout_err, hit);
        if (data_data_ok) checkOutput("data_ok_legal", (m_cnt != 0), 1);

        if (resetn) begin
            issue = e_req & data_addr_ok;
            dec   = data_data_ok && (m_cnt > 0);
            cnt_n = m_cnt + (issue ? 1 : 0) - (dec ? 1 : 0);
            m_wd  = (hit || !active || data_data_ok || data_addr_ok) ? 0 : m_wd + 1;
            if (hit) begin
                m_busy = 0; m_killed = 0; cnt_n = 0;
            end else if (m_busy) begin
                if (!m_armed) begin
                    if (flush)           m_busy = 0;
                    else if (cnt_n == 0) m_armed = 1;
                end else begin
                    if (flush) m_killed = 1;
                    if (issue) begin
                        m_issued = 1;
                        if (!m_load) m_busy = 0;
                    end else if (m_issued && data_data_ok) begin
                        m_busy = 0;
                    end
                end
                if (!m_busy) m_killed = 0;
            end else if (acc) begin
                if (mem_write) begin
                    if (m_cnt < MAX_OUT) begin
                        m_busy = 1; m_load = 0; m_armed = 1; m_issued = 0; m_killed = 0;
                    end
                end else begin
                    m_busy = 1; m_load = 1; m_armed = (m_cnt == 0); m_issued = 0; m_killed = 0;
                end
            end
            m_cnt = cnt_n;
        end
    end

    initial begin
        int first_hit;
        #3;
        checkOutput("rst_req", data_req, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_stall", dm_stall, 0);
        checkOutput("rst_load_done", load_done, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] uncached store with slow addr_ok");
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("st_first_stall", dm_stall, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("st_req", data_req, 1);
        checkOutput("st_wr", data_wr, 1);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        checkOutput("st_accept_stall", dm_stall, 0);
        idleCycle(0);
        checkOutput("st_outstanding1", outstanding, 1);
        repeat (3) idleCycle(0);
        idleCycle(1);
        idleCycle(0);
        checkOutput("st_outstanding0", outstanding, 0);

        $display("[TB] five posted stores against a limit of four");
        repeat (4) fastStore();
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("full_req", data_req, 0);
        checkOutput("full_stall", dm_stall, 1);
        checkOutput("full_outstanding", outstanding, 4);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("full_after_dok", outstanding, 3);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        checkOutput("full_issue_req", data_req, 1);
        checkOutput("full_issue_stall", dm_stall, 0);
        idleCycle(1);
        checkOutput("full_outstanding_again", outstanding, 4);
        repeat (3) idleCycle(1);
        idleCycle(0);
        checkOutput("full_drained", outstanding, 0);

        $display("[TB] uncached load behind two posted stores");
        repeat (2) fastStore();
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 1);
        checkOutput("ld_drain_req", data_req, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 1);
        checkOutput("ld_drain_last", data_req, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 0);
        checkOutput("ld_req", data_req, 1);
        checkOutput("ld_req_rd", data_wr, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("ld_wait_stall", dm_stall, 1);
        applyStimulus(1, 0, 1, 0, 0, 0, 1);
        checkOutput("ld_done", load_done, 1);
        checkOutput("ld_done_stall", dm_stall, 0);
        idleCycle(0);

        $display("[TB] cached load against cache busy and posted store");
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("c_cache_stall", dm_stall, 1);
        checkOutput("c_no_req", data_req, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        fastStore();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("c_order_stall", dm_stall, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("c_released", dm_stall, 0);
        idleCycle(0);

        $display("[TB] flush of a load in REQ");
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        checkOutput("fl_req_held", data_req, 1);
        checkOutput("fl_stall", dm_stall, 0);
        idleCycle(0);
        checkOutput("fl_req_still", data_req, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checkOutput("fl_new_access_stall", dm_stall, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("fl_no_load_done", load_done, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_back_idle", dm_stall, 0);
        idleCycle(0);

        $display("[TB] flush of a load while draining");
        fastStore();
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        idleCycle(1);
        checkOutput("fd_no_req", data_req, 0);
        idleCycle(0);

        $display("[TB] reset in the middle of a drain");
        fastStore();
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        checkOutput("mid_rst_outstanding", outstanding, 0);
        checkOutput("mid_rst_req", data_req, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        idleCycle(0);

`ifdef DM_ACCESS_TIMEOUT_EN
        $display("[TB] watchdog on a load that never returns");
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 0);
        first_hit = 0;
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 0, 0);
            if (timeout_err === 1'b1) begin
                first_hit = i;
                break;
            end
        end
        checkOutput("wd_cycles", first_hit, 16);
        idleCycle(0);
        checkOutput("wd_outstanding", outstanding, 0);
        checkOutput("wd_idle", data_req, 0);
`else
        first_hit = 0;
        for (int i = 1; i <= 20; i++) begin
            idleCycle(0);
            if (timeout_err === 1'b1) first_hit = i;
        end
        checkOutput("no_wd", first_hit, 0);
`endif
        repeat (2) idleCycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Parametrised data-memory access/stall controller for the MEM stage.
- Sits between the MEM stage and the SRAM-like data bus (req/addr_ok/data_ok).
- Posts uncached stores (up to MAX_OUTSTANDING in flight) and blocks uncached loads until the data returns.
- Enforces ordering: uncached loads and cached accesses wait until all older posted stores have drained.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-not-completed uncached requests; range 1..15.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.
- Derived localparam CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_read  in  1  MEM-stage instruction is a load (lb/lbu/lh/lhu/lw).
- mem_write  in  1  MEM-stage instruction is a store (sb/sh/sw).
- uncached  in  1  MEM-stage access is uncached.
- cache_stall  in  1  cache busy on a cached access.
- flush  in  1  MEM-stage instruction is being killed (exception/eret).
- data_req  out  1  bus request valid.
- data_wr  out  1  bus request is a write; valid while data_req=1.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  oldest outstanding request completed.
- dm_stall  out  1  freeze the pipeline at MEM (combinational).
- load_done  out  1  one-cycle pulse: load data valid on the bus, capture it.
- outstanding  out  CNT_W  current in-flight request count.
- timeout_err  out  1  watchdog pulse (optional feature).

Behaviour:
- Reset state: FSM=IDLE, outstanding=0, flushed=0, all outputs 0.
- acc = (mem_read|mem_write) & uncached & !flush.
- Counter update:
  - +1 on data_req&data_addr_ok; -1 on data_data_ok; both in the same cycle: unchanged.
  - data_data_ok with outstanding=0 is ignored (bench asserts it never happens).
- FSM states: IDLE, REQ, DRAIN, LOAD_WAIT.
  - data_req=(state==REQ); data_wr registered on entry to REQ and held stable until accepted.
- IDLE:
  - acc & mem_write & outstanding<MAX_OUTSTANDING -> REQ.
  - acc & mem_write at full count -> stay IDLE (stall).
  - acc & mem_read: outstanding=0 -> REQ, else -> DRAIN.
- DRAIN:
  - (outstanding=0) or (outstanding=1 & data_data_ok) -> REQ.
  - flush -> IDLE.
- REQ:
  - Request held until data_addr_ok; flush cannot retract it.
  - On accept: write -> IDLE; read -> LOAD_WAIT.
- LOAD_WAIT:
  - data_data_ok with outstanding=1 -> IDLE.
  - load_done = data_data_ok & !flushed in that cycle.
- flushed flag:
  - Set when flush occurs in REQ or LOAD_WAIT; cleared on return to IDLE.
  - While set, the transaction completes in the background and dm_stall ignores it.
- dm_stall, uncached access (acc=1):
  - 1 from the first cycle the access is seen.
  - Drops to 0 in the completing cycle only: store accept (REQ & data_addr_ok & data_wr), or load return (LOAD_WAIT & data_data_ok).
  - The instruction therefore advances exactly once.
- dm_stall, cached access (!uncached):
  - cache_stall | (outstanding!=0).
  - The FSM is not involved.
- dm_stall, general:
  - Any new access while FSM!=IDLE with flushed=1 -> dm_stall=1 until IDLE.
  - No access or flush=1 -> dm_stall=0.
- Latency:
  - Uncached store with immediate addr_ok: 1 stall cycle.
  - Uncached load: 1 + addr wait + data wait cycles.
- Reset mid-transaction: immediate return to reset state; the bus is reset by the same resetn.

Optional Feature:
- Macro: DM_ACCESS_TIMEOUT_EN.
- Defined:
  - Counter runs while FSM!=IDLE or outstanding!=0 with no data_data_ok; cleared on any data_data_ok or data_addr_ok.
  - On reaching TIMEOUT_CYCLES: timeout_err pulses 1 cycle, FSM forced to IDLE, outstanding cleared, flushed cleared, dm_stall=0 that cycle.
- Undefined: no counter; timeout_err tied to 0.

Test Plan:
- Uncached sw, addr_ok on 2nd REQ cycle, data_ok 5 cycles later -> dm_stall=1 for 2 cycles; outstanding 0->1->0.
- 5 back-to-back uncached sw, addr_ok immediate, no data_ok, MAX_OUTSTANDING=4 -> 5th holds data_req=0, dm_stall=1, outstanding=4; one data_ok -> 5th issues, outstanding stays 4.
- Uncached lw with 2 stores pending -> DRAIN until 2nd data_ok, then REQ; load_done=1 and dm_stall=0 in the load's data_ok cycle.
- Cached lw: cache_stall=1, outstanding=0 -> dm_stall=1, data_req=0. cache_stall=0, outstanding=1 -> dm_stall=1 until data_ok.
- flush during REQ for lw -> data_req held until addr_ok; dm_stall=0 from the flush cycle; load_done never pulses; FSM back to IDLE at data_ok.
- DM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16, lw with no data_ok -> timeout_err pulse 16 cycles after accept; FSM=IDLE; outstanding=0.
